// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised, majority-voted input, optional parity,
// one or two stop bits, and a valid/ready holding register with error flags.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic [2:0]             hist_q;
    logic                   vote;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;

    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   ovr_q, ovr_d;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    // State register; synchroniser and history reset high so release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            hist_q     <= 3'b111;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            rx_prev_q  <= rx_s;
            hist_q     <= {hist_q[1:0], rx_s};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    // cnt_q is cycles since the previous sample point minus one, so it never needs to hold CLKS_PER_BIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s && rx_prev_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (vote) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    perr_d  = ((^shreg_q) ^ vote) != (PARITY == 1);
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (!vote) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: an accept and a load in the same cycle leave rx_valid set with the new word.
    always_comb begin
        busy       = (state_q != S_IDLE);
        valid_d    = valid_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;
        if (valid_q && rx_ready) begin
            valid_d    = 1'b0;
            perr_out_d = 1'b0;
            ferr_out_d = 1'b0;
        end
        if (state_q == S_DONE) begin
            if (!valid_q || rx_ready) begin
                valid_d    = 1'b1;
                data_d     = shreg_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: four instances (8N1, 8E1, 8N2, 7O2) at 16 clocks per bit,
// driven from a bit-level frame generator and compared against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] line  = 4'hF;
    logic [3:0] ready = 4'hF;
    logic [3:0] valid, perr, ferr, ovr, busy;
    logic [7:0] dA, dB, dC;
    logic [6:0] dD;

    int checks = 0;
    int errors = 0;

    logic [12:0] gotq[$];
    int ovr_run[4];
    int ovr_pulses[4];
    int ovr_last[4];

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) uA (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[0]), .rx_data(dA), .rx_valid(valid[0]), .rx_ready(ready[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) uB (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[1]), .rx_data(dB), .rx_valid(valid[1]), .rx_ready(ready[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) uC (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[2]), .rx_data(dC), .rx_valid(valid[2]), .rx_ready(ready[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2]));
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(3)) uD (
        .clk(clk), .rst_n(rst_n), .uart_rx(line[3]), .rx_data(dD), .rx_valid(valid[3]), .rx_ready(ready[3]),
        .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]), .busy(busy[3]));

    function automatic int dbits(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int par(input int i);
        return (i == 1) ? 2 : ((i == 3) ? 1 : 0);
    endfunction

    function automatic int stops(input int i);
        return (i >= 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] getdata(input int i);
        case (i)
            0:       return {1'b0, dA};
            1:       return {1'b0, dB};
            2:       return {1'b0, dC};
            default: return {2'b00, dD};
        endcase
    endfunction

    function automatic logic [13:0] getstat(input int i);
        return {getdata(i), valid[i], perr[i], ferr[i], ovr[i], busy[i]};
    endfunction

    // Reference model: word, parity verdict by counting ones, frame verdict from the stop bits sent.
    function automatic logic [10:0] model(input int i, input logic [8:0] d, input logic pbit, input logic [1:0] sm);
        logic [8:0] dm;
        int         ones;
        logic       pe, fe;
        dm   = d & ((9'd1 << dbits(i)) - 9'd1);
        ones = $countones(dm) + int'(pbit);
        pe   = 1'b0;
        if (par(i) == 1) pe = (ones % 2) != 1;
        if (par(i) == 2) pe = (ones % 2) != 0;
        fe = 1'b0;
        for (int s = 0; s < stops(i); s++) if (sm[s]) fe = 1'b1;
        return {fe, pe, dm};
    endfunction

    // Acceptance monitor: logs every handshake and measures overrun pulses.
    always begin
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (valid[i] && ready[i]) gotq.push_back({2'(i), ferr[i], perr[i], getdata(i)});
            if (ovr[i]) begin
                ovr_run[i]++;
            end else if (ovr_run[i] > 0) begin
                ovr_pulses[i]++;
                ovr_last[i] = ovr_run[i];
                ovr_run[i]  = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input int i, input logic v, input bit glitch);
        for (int c = 0; c < CPB; c++) begin
            line[i] = (glitch && c == 6) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int i, input logic [8:0] d, input logic pbit, input logic [1:0] sm, input int glitch);
        drive_bit(i, 1'b0, 1'b0);
        for (int b = 0; b < dbits(i); b++) drive_bit(i, d[b], glitch == b);
        if (par(i) != 0) drive_bit(i, pbit, 1'b0);
        for (int s = 0; s < stops(i); s++) drive_bit(i, ~sm[s], 1'b0);
        line[i] = 1'b1;
    endtask

    task automatic send_partial(input int i, input logic [8:0] d);
        drive_bit(i, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) drive_bit(i, d[b], 1'b0);
        line[i] = d[4];
        cyc(CPB / 2);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (getstat(i) !== 14'h0) begin
                errors++;
                $display("[TB] FAIL reset_state dut%0d: got %h expected %h", i, getstat(i), 14'h0);
            end
        end
        rst_n = 1'b1;
        cyc(5);
    endtask

    task automatic test_basic;
        int unstable = 0;
        ready[0] = 1'b0;
        gotq.delete();
        send_frame(0, 9'h0A5, 1'b0, 2'b00, -1);
        for (int k = 0; k < 40 && !valid[0]; k++) @(negedge clk);
        checks++;
        if ({valid[0], perr[0], ferr[0], dA} !== {3'b100, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL basic_word: got v%b p%b f%b %h expected v1 p0 f0 a5", valid[0], perr[0], ferr[0], dA);
        end
        for (int k = 0; k < 50; k++) begin
            if ({valid[0], perr[0], ferr[0], dA} !== {3'b100, 8'hA5}) unstable++;
            cyc(1);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("[TB] FAIL basic_hold: got %0d unstable cycles expected 0", unstable);
        end
        ready[0] = 1'b1;
        cyc(1);
        ready[0] = 1'b0;
        checks++;
        if (valid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_accept: got rx_valid %b expected 0", valid[0]);
        end
        checks++;
        if (gotq.size() != 1 || gotq[0] !== {2'd0, 3'b000, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL basic_handshake: got %0d words (first %h) expected 1 word %h",
                     gotq.size(), (gotq.size() > 0) ? gotq[0] : 13'h0, {2'd0, 3'b000, 8'hA5});
        end
        ready[0] = 1'b1;
        cyc(5);
    endtask

    task automatic test_parity;
        logic [8:0]  d;
        logic        p;
        logic [12:0] want, got;
        for (int n = 0; n < 10; n++) begin
            d = (n < 2) ? 9'h003 : 9'($urandom_range(0, 255));
            p = (n == 0) ? 1'b1 : ((n == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
            gotq.delete();
            send_frame(1, d, p, 2'b00, -1);
            cyc(20);
            want = {2'd1, model(1, d, p, 2'b00)};
            got  = (gotq.size() > 0) ? gotq.pop_front() : 13'h1FFF;
            checks++;
            if (got !== want || gotq.size() != 0) begin
                errors++;
                $display("[TB] FAIL parity_frame%0d: got %h expected %h", n, got, want);
            end
        end
    endtask

    task automatic test_stop_bits;
        logic [8:0]  d;
        logic [1:0]  sm;
        logic [12:0] want, got;
        for (int n = 0; n < 2; n++) begin
            d  = (n == 0) ? 9'h05A : 9'h011;
            sm = (n == 0) ? 2'b10 : 2'b00;
            gotq.delete();
            send_frame(2, d, 1'b0, sm, -1);
            cyc(20);
            want = {2'd2, model(2, d, 1'b0, sm)};
            got  = (gotq.size() > 0) ? gotq.pop_front() : 13'h1FFF;
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL stop_frame%0d: got %h expected %h", n, got, want);
            end
        end
        gotq.delete();
        line[2] = 1'b0;
        cyc(12 * CPB);
        line[2] = 1'b1;
        cyc(3 * CPB);
        want = {2'd2, 3'b100, 8'h00};
        checks++;
        if (gotq.size() != 1 || gotq[0] !== want) begin
            errors++;
            $display("[TB] FAIL break_frame: got %0d words (first %h) expected 1 word %h",
                     gotq.size(), (gotq.size() > 0) ? gotq[0] : 13'h0, want);
        end
    endtask

    task automatic test_glitch;
        int hi = 0;
        logic [12:0] got;
        gotq.delete();
        line[0] = 1'b0;
        cyc(3);
        line[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (busy[0]) hi++;
            cyc(1);
        end
        checks++;
        if (hi < 1 || hi > CPB / 2 + 1) begin
            errors++;
            $display("[TB] FAIL false_start_busy: got %0d busy cycles expected 1..%0d", hi, CPB / 2 + 1);
        end
        checks++;
        if (gotq.size() != 0) begin
            errors++;
            $display("[TB] FAIL false_start_word: got %0d words expected 0", gotq.size());
        end
        send_frame(0, 9'h000, 1'b0, 2'b00, 3);
        cyc(20);
        got = (gotq.size() > 0) ? gotq.pop_front() : 13'h1FFF;
        checks++;
        if (got !== 13'h0000) begin
            errors++;
            $display("[TB] FAIL glitch_vote: got %h expected %h", got, 13'h0000);
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        ready[0] = 1'b0;
        gotq.delete();
        p0 = ovr_pulses[0];
        send_frame(0, 9'h012, 1'b0, 2'b00, -1);
        send_frame(0, 9'h034, 1'b0, 2'b00, -1);
        cyc(4);
        checks++;
        if ({valid[0], dA} !== {1'b1, 8'h12}) begin
            errors++;
            $display("[TB] FAIL b2b_held: got v%b %h expected v1 12", valid[0], dA);
        end
        checks++;
        if (ovr_pulses[0] - p0 != 1 || ovr_last[0] != 1) begin
            errors++;
            $display("[TB] FAIL b2b_overrun: got %0d pulses of length %0d expected 1 of length 1",
                     ovr_pulses[0] - p0, ovr_last[0]);
        end
        ready[0] = 1'b1;
        cyc(20);
        checks++;
        if (gotq.size() != 1 || gotq[0] !== {2'd0, 3'b000, 8'h12} || valid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %0d words (first %h) valid %b expected 1 word %h valid 0",
                     gotq.size(), (gotq.size() > 0) ? gotq[0] : 13'h0, valid[0], {2'd0, 3'b000, 8'h12});
        end
    endtask

    task automatic test_random;
        logic [8:0]  d;
        logic        p;
        logic [1:0]  sm;
        logic [12:0] want, got;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) begin
                d  = 9'($urandom_range(0, 511));
                p  = 1'($urandom_range(0, 1));
                sm = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                gotq.delete();
                send_frame(i, d, p, sm, -1);
                cyc(20 + $urandom_range(0, 10));
                want = {2'(i), model(i, d, p, sm)};
                got  = (gotq.size() > 0) ? gotq.pop_front() : 13'h1FFF;
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("[TB] FAIL random_dut%0d_frame%0d: got %h expected %h", i, n, got, want);
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic        pD;
        logic [12:0] got;
        gotq.delete();
        fork
            send_partial(0, 9'($urandom_range(0, 255)));
            send_partial(3, 9'($urandom_range(0, 127)));
        join
        rst_n = 1'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (getstat(i) !== 14'h0) begin
                errors++;
                $display("[TB] FAIL midframe_reset dut%0d: got %h expected %h", i, getstat(i), 14'h0);
            end
        end
        line[0] = 1'b1;
        line[3] = 1'b1;
        cyc(40);
        rst_n = 1'b1;
        cyc(5);
        checks++;
        if (gotq.size() != 0 || busy !== 4'h0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %0d words busy %b expected 0 words busy 0000", gotq.size(), busy);
        end
        pD = ($countones(7'h55) % 2) == 0;
        fork
            send_frame(0, 9'h0C3, 1'b0, 2'b00, -1);
            send_frame(3, 9'h055, pD, 2'b00, -1);
        join
        cyc(20);
        got = (gotq.size() > 0) ? gotq.pop_front() : 13'h1FFF;
        checks++;
        if (got !== {2'd0, model(0, 9'h0C3, 1'b0, 2'b00)}) begin
            errors++;
            $display("[TB] FAIL resume_8bit: got %h expected %h", got, {2'd0, model(0, 9'h0C3, 1'b0, 2'b00)});
        end
        got = (gotq.size() > 0) ? gotq.pop_front() : 13'h1FFF;
        checks++;
        if (got !== {2'd3, model(3, 9'h055, pD, 2'b00)}) begin
            errors++;
            $display("[TB] FAIL resume_7bit: got %h expected %h", got, {2'd3, model(3, 9'h055, pD, 2'b00)});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_stop_bits();
        test_glitch();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached before the sequence ended");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 LED receiver.
- Configurable data width, parity and stop bits.
- Input is synchronised, each bit is majority-voted from three samples, and start bits are validated.
- Reports parity, framing and overrun errors.
- Delivers each byte through a valid/ready holding register, so it can feed a FIFO, command decoder or bus bridge.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (CLOCK_FREQ/BAUD); minimum 8.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
SYNC_STAGES, 2, flip-flops in the rx input synchroniser; minimum 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
uart_rx  in  1  serial line; idles high.
rx_data  out  DATA_BITS  received word, LSB = first bit on the wire.
rx_valid  out  1  rx_data and the error flags are valid.
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
parity_err  out  1  parity mismatch for the held word; always 0 when PARITY = 0.
frame_err  out  1  at least one stop bit was sampled low for the held word.
overrun  out  1  one-cycle pulse when a completed frame is dropped.
busy  out  1  high in every FSM state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser flops = 1, FSM = IDLE, counters = 0.
  - rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
- Synchroniser: rx_s = uart_rx delayed by SYNC_STAGES flops. Sample history h[2:0] shifts in rx_s every cycle. vote = majority(h).
- HALF = CLKS_PER_BIT/2 (integer division).
- Bit counter width = clog2(DATA_BITS+1). Cycle counter width = clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - A falling edge (rx_s = 0 while the previous rx_s = 1) defines cycle T0.
  - Go to START with counter = 1.
- START:
  - At T0+HALF, test vote.
  - vote = 1: false start; return to IDLE with no output and no error.
  - vote = 0: go to DATA, counter = 1, bit index = 0.
- DATA:
  - Bit k is sampled (vote) at T0 + HALF + (k+1)*CLKS_PER_BIT and shifted in LSB-first.
  - After bit DATA_BITS-1, go to PARITY if PARITY != 0, otherwise STOP.
- PARITY:
  - Sampled one bit period after the last data bit.
  - Error if XOR(data, parity bit) != expected: expected is 1 for odd, 0 for even.
- STOP:
  - Each stop bit is sampled one bit period after the previous sample.
  - Any low sample sets the frame error.
  - After the last stop sample, go to DONE (one cycle).
  - No wait for the stop-bit end, so a start edge immediately following is caught.
- DONE, holding register not occupied (!rx_valid, or rx_valid && rx_ready in the same cycle):
  - Load rx_data, parity_err and frame_err.
  - rx_valid = 1 on the next cycle.
  - Return to IDLE.
- DONE, holding register occupied (rx_valid && !rx_ready):
  - Drop the new frame; the held word and flags are unchanged.
  - overrun = 1 for exactly one cycle.
  - Return to IDLE.
- Handshake:
  - rx_valid is held until the cycle rx_valid && rx_ready, after which it clears.
  - rx_data, parity_err and frame_err stay stable while rx_valid = 1.
  - The error flags clear together with rx_valid.
  - Accept and load in the same cycle is legal: rx_valid stays 1 and the new word appears.
- Frames with errors are still delivered (flags attached), never silently discarded.
- Break (line held low): produces a frame of all zeros with frame_err = 1. The FSM then waits in IDLE for a genuine falling edge, because rx_s must return high first.
- Reset mid-frame: the frame is abandoned, outputs return to reset values, and the receiver resumes at the next falling edge after release.
- Latency: rx_valid rises 2 cycles after the final stop-bit sample cycle.

Test Plan:
1. CLKS_PER_BIT = 16, 8N1, send 0xA5 -> rx_data = 0xA5, rx_valid = 1, parity_err = 0, frame_err = 0. Hold rx_ready = 0 for 50 cycles -> outputs stable. Pulse rx_ready -> rx_valid = 0 next cycle.
2. PARITY = 2 (even), send 0x03 with parity bit 1 -> rx_data = 0x03, parity_err = 1. Resend with parity bit 0 -> parity_err = 0.
3. STOP_BITS = 2, send 0x5A with the second stop bit low -> rx_data = 0x5A, frame_err = 1. Next clean frame 0x11 -> frame_err = 0.
4. Glitches:
   - 3-cycle low pulse on an idle line -> no rx_valid, busy returns to 0 within HALF+1 cycles.
   - 1-cycle inverted glitch centred on the bit-3 sample of 0x00 -> rx_data = 0x00 (majority rejects it).
5. Two back-to-back frames 0x12 then 0x34 with rx_ready = 0 -> rx_data = 0x12 retained, overrun pulses once for exactly 1 cycle. Then rx_ready = 1 -> 0x12 consumed, no 0x34 delivered.
6. Reset:
   - Assert rst_n = 0 during bit 4 of a frame -> all outputs at reset values.
   - Release and send 0xC3 -> rx_data = 0xC3, no errors.
   - Repeat with DATA_BITS = 7, send 0x55 -> rx_data = 7'h55.
